// File: rtl/loac_mem_pkg.sv
// Shared types and the write-pattern rule for the RAM built-in self test.
package loac_mem_pkg;

  localparam int unsigned DEF_ENDERECO = 2;
  localparam int unsigned DEF_DADO     = 4;

  typedef enum logic [2:0] {IDLE, WRITE, READ, CHECK, DONE} bist_state_t;

  // Width-agnostic: callers truncate the result to their data width.
  function automatic logic [31:0] exp_data(input logic [31:0] seed,
                                           input logic [31:0] addr,
                                           input logic        mode);
    logic [31:0] v;
    v = seed + addr;
    return mode ? ~v : v;
  endfunction

endpackage

// File: rtl/mem_bist_initiator.sv
// RAM BIST initiator: fills the RAM with a seed pattern, reads it back,
// and reports pass, mismatch count and first failing address.
module mem_bist_initiator
  import loac_mem_pkg::*;
#(
  parameter int unsigned ENDERECO = loac_mem_pkg::DEF_ENDERECO,
  parameter int unsigned DADO     = loac_mem_pkg::DEF_DADO
) (
  input  logic                clk_2,
  input  logic                reset,
  input  logic                start,
  input  logic                mode,
  input  logic [DADO-1:0]     seed,
  output logic [ENDERECO-1:0] endereco,
  output logic [DADO-1:0]     dadoescrito,
  output logic                wr_en,
  input  logic [DADO-1:0]     dadolido,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ENDERECO:0]   err_count,
  output logic [ENDERECO-1:0] fail_addr
);

  localparam int unsigned N = 2 ** ENDERECO;

  bist_state_t         state, state_nxt;
  logic [ENDERECO-1:0] addr;
  logic [ENDERECO-1:0] cmp_addr;
  logic [DADO-1:0]     seed_q;
  logic                mode_q;
  logic [DADO-1:0]     exp_cur;
  logic [DADO-1:0]     exp_cmp;
  logic                compare_en;
  logic                mismatch;

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = WRITE;
      WRITE:   if (addr == ENDERECO'(N - 1)) state_nxt = READ;
      READ:    if (addr == ENDERECO'(N - 1)) state_nxt = CHECK;
      CHECK:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wr_en       = (state == WRITE);
    busy        = (state == WRITE) || (state == READ) || (state == CHECK);
    done        = (state == DONE);
    endereco    = addr;
    dadoescrito = (state == WRITE) ? exp_cur : '0;
  end

  // Read data lags the address by one cycle; in CHECK addr has wrapped to 0,
  // so addr-1 is N-1 there as well.
  always_comb begin
    cmp_addr   = addr - ENDERECO'(1);
    exp_cur    = DADO'(exp_data(32'(seed_q), 32'(addr), mode_q));
    exp_cmp    = DADO'(exp_data(32'(seed_q), 32'(cmp_addr), mode_q));
    compare_en = ((state == READ) && (addr != '0)) || (state == CHECK);
    mismatch   = compare_en && (dadolido != exp_cmp);
  end

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      addr      <= '0;
      seed_q    <= '0;
      mode_q    <= 1'b0;
      err_count <= '0;
      fail_addr <= '0;
      pass      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            seed_q    <= seed;
            mode_q    <= mode;
            err_count <= '0;
            fail_addr <= '0;
            pass      <= 1'b0;
            addr      <= '0;
          end
        end
        WRITE, READ: addr <= addr + ENDERECO'(1);
        default: ;
      endcase
      if (mismatch) begin
        if (err_count != (ENDERECO + 1)'(N)) err_count <= err_count + 1'b1;
        if (err_count == '0)                 fail_addr <= cmp_addr;
      end
      if (state == CHECK) pass <= (err_count == '0) && !mismatch;
    end
  end

endmodule

// File: tb/tb_mem_bist_initiator.sv
// Scoreboard bench for mem_bist_initiator with a behavioural RAM and fault injection.
module tb_mem_bist_initiator;

  logic       clk_2 = 1'b0;
  logic       reset;
  logic       start;
  logic       mode;
  logic [3:0] seed;
  logic [1:0] endereco;
  logic [3:0] dadoescrito;
  logic       wr_en;
  logic [3:0] dadolido;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [1:0] fail_addr;

  mem_bist_initiator #(.ENDERECO(2), .DADO(4)) dut (
    .clk_2(clk_2), .reset(reset), .start(start), .mode(mode), .seed(seed),
    .endereco(endereco), .dadoescrito(dadoescrito), .wr_en(wr_en),
    .dadolido(dadolido), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_addr(fail_addr)
  );

  always #5 clk_2 = ~clk_2;

  int cyc = 0;
  always @(posedge clk_2) cyc <= cyc + 1;

  // Behavioural RAM: registered read, per-word stuck-at-0 bit mask on store.
  logic [3:0] mem [4];
  logic [3:0] fault_mask [4];
  always @(posedge clk_2) begin
    if (wr_en) mem[endereco] <= dadoescrito & ~fault_mask[endereco];
    dadolido <= mem[endereco];
  end

  typedef struct { int cycle; logic ok; logic [2:0] errs; logic [1:0] faddr; } res_t;
  typedef struct { logic [1:0] a; logic [3:0] d; } wr_t;
  res_t res_q[$];
  wr_t  wr_q[$];

  int checks = 0, errors = 0, done_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [3:0] pattern(input logic [3:0] s, input int a, input logic m);
    int v;
    v = (int'(s) + a) % 16;
    if (m) v = 15 - v;
    return 4'(v);
  endfunction

  // Expected behaviour of one complete test accepted in cycle k.
  task automatic push_test(input int k, input logic [3:0] s, input logic m);
    res_t r;
    wr_t  w;
    logic [3:0] e;
    int nerr, first;
    nerr = 0; first = 0;
    for (int a = 0; a < 4; a++) begin
      e = pattern(s, a, m);
      w.a = 2'(a); w.d = e;
      wr_q.push_back(w);
      if ((e & fault_mask[a]) != 4'h0) begin
        if (nerr == 0) first = a;
        nerr++;
      end
    end
    r.cycle = k + 10; r.ok = (nerr == 0); r.errs = 3'(nerr); r.faddr = 2'(first);
    res_q.push_back(r);
  endtask

  always @(negedge clk_2) begin
    if (wr_en) begin
      if (wr_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: got addr %0d data %0h, expected no write", endereco, dadoescrito);
      end else begin
        wr_t w;
        w = wr_q.pop_front();
        check("wr_addr", 32'(endereco), 32'(w.a));
        check("wr_data", 32'(dadoescrito), 32'(w.d));
      end
    end
    if (done) begin
      done_seen++;
      if (res_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done=1, expected 0 (cycle %0d)", cyc);
      end else begin
        res_t r;
        r = res_q.pop_front();
        check("done_cycle", 32'(cyc), 32'(r.cycle));
        check("pass", 32'(pass), 32'(r.ok));
        check("err_count", 32'(err_count), 32'(r.errs));
        check("fail_addr", 32'(fail_addr), 32'(r.faddr));
        check("busy_at_done", 32'(busy), 32'(0));
      end
    end
  end

  task automatic start_test(input logic [3:0] s, input logic m);
    @(negedge clk_2);
    seed = s; mode = m; start = 1'b1;
    push_test(cyc, s, m);
    @(negedge clk_2);
    start = 1'b0;
    seed  = 4'($urandom);
    mode  = 1'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((res_q.size() != 0) && (n < 80)) begin
      @(posedge clk_2);
      n++;
    end
    if (res_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done within %0d cycles, expected done", n);
      res_q.delete();
      wr_q.delete();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_endereco"}, 32'(endereco), 32'(0));
    check({tag, "_dadoescrito"}, 32'(dadoescrito), 32'(0));
    check({tag, "_wr_en"}, 32'(wr_en), 32'(0));
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_done"}, 32'(done), 32'(0));
    check({tag, "_pass"}, 32'(pass), 32'(0));
    check({tag, "_err_count"}, 32'(err_count), 32'(0));
    check({tag, "_fail_addr"}, 32'(fail_addr), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected bench to complete");
    $fatal(1);
  end

  initial begin
    int d0, k;
    reset = 1'b1; start = 1'b0; mode = 1'b0; seed = 4'h0;
    for (int a = 0; a < 4; a++) begin mem[a] = 4'h0; fault_mask[a] = 4'h0; end
    repeat (3) @(negedge clk_2);
    check_all_zero("reset");
    #2 reset = 1'b0;

    start_test(4'h3, 1'b0); wait_idle();
    start_test(4'hE, 1'b0); wait_idle();
    start_test(4'h0, 1'b1); wait_idle();

    fault_mask[2] = 4'b0001;
    start_test(4'h3, 1'b0); wait_idle();
    fault_mask[2] = 4'h0;

    // Reset in the WRITE cycle with addr=1.
    start_test(4'h7, 1'b0);
    @(negedge clk_2);
    #2 reset = 1'b1;
    #1 check_all_zero("abort");
    res_q.delete(); wr_q.delete();
    d0 = done_seen;
    repeat (15) @(negedge clk_2);
    check("no_done_after_abort", 32'(done_seen - d0), 32'(0));
    #2 reset = 1'b0;
    start_test(4'h9, 1'b1); wait_idle();

    // Start pulsed again during READ is ignored.
    d0 = done_seen;
    start_test(4'h5, 1'b0);
    repeat (5) @(negedge clk_2);
    start = 1'b1;
    @(negedge clk_2);
    start = 1'b0;
    wait_idle();
    repeat (12) @(negedge clk_2);
    check("single_done", 32'(done_seen - d0), 32'(1));

    // Start held high: tests every 11 cycles.
    @(negedge clk_2);
    k = cyc; seed = 4'hA; mode = 1'b1; start = 1'b1;
    push_test(k, 4'hA, 1'b1);
    push_test(k + 11, 4'hA, 1'b1);
    push_test(k + 22, 4'hA, 1'b1);
    repeat (23) @(negedge clk_2);
    start = 1'b0;
    wait_idle();

    for (int t = 0; t < 20; t++) begin
      for (int a = 0; a < 4; a++)
        fault_mask[a] = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      start_test(4'($urandom), 1'($urandom));
      wait_idle();
    end
    for (int a = 0; a < 4; a++) fault_mask[a] = 4'h0;

    repeat (4) @(negedge clk_2);
    check("write_queue_drained", 32'(wr_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
